multi_band_centroid: RTL and testbench
======================================

Name: multi_band_centroid

Overview:
- Parametrised successor to the single-ROI line centroid tracker.
- Splits the bottom of the frame into N_BANDS horizontal bands and accumulates per-band pixel-x sums and counts.
- At frame end, runs one shared serial divider per band and emits per-band centroid records over a valid/ready handshake.
- Sits between the thresholded convolution output stream and the steering controller; supports look-ahead steering from upper bands.

Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- PIX_W, 4, input pixel width
- N_BANDS, 4, number of ROI bands (1..8)
- BAND_H, 32, rows per band; requires N_BANDS*BAND_H <= IMG_H
- THRESH, 0, a pixel is "on" when pix_data > THRESH (unsigned)
- MIN_PIX, 1, a band with count < MIN_PIX reports lost

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pix_valid  in  1  pixel strobe, raster order
- pix_data  in  PIX_W  pixel value
- sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0)
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_band  out  clog2(N_BANDS) max 1  band index; 0 = bottom-most
- res_x  out  clog2(IMG_W)  centroid x, floor(sum_x/count); 0 when lost
- res_count  out  SP_W  on-pixel count of the band
- res_lost  out  1  count < MIN_PIX
- frame_done  out  1  1-cycle pulse after the last band record is accepted
- overrun  out  1  sticky; frame end occurred while results were pending; cleared by rst only
- frame_err  out  1  1-cycle pulse on sof arriving mid-frame

Behaviour:
- Reset: x, y, all accumulators and snapshots = 0; FSM = IDLE; all outputs 0.
- Widths: SX_W = clog2(BAND_H*IMG_W*IMG_W/2 + 1); SP_W = clog2(BAND_H*IMG_W + 1). Accumulators never saturate at these widths.
- Position counters:
  - On pix_valid, x increments; at IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), end of frame (EOF) is asserted for that cycle and x, y wrap to 0.
- sof handling:
  - pix_valid && sof treats the current pixel as (0,0), overriding the counters.
  - If (x,y) != (0,0) at that time: frame_err pulses, all accumulators clear, and the partial frame is discarded (no EOF).
- Band mapping: band k covers rows IMG_H-(k+1)*BAND_H through IMG_H-k*BAND_H-1. Rows above all bands are ignored.
- Accumulate: for an on-pixel in band k, sum_x[k] += x and cnt[k] += 1, same cycle.
- EOF snapshot:
  - In the EOF cycle the final pixel is included in the snapshot (combinational add).
  - All sums and counts copy to snapshot registers and the accumulators clear.
  - FSM leaves IDLE and goes to DIV, with band = 0.
  - If the FSM is not IDLE at EOF: overrun is set, the snapshot is not overwritten, and the accumulators still clear.
- FSM:
  - IDLE -> DIV on EOF.
  - DIV:
    - If cnt < MIN_PIX: skip division, result x = 0, lost = 1, go to OUT next cycle.
    - Else: start serial_divider; wait for done; go to OUT.
  - OUT:
    - res_valid = 1. Record fields are stable while res_valid && !res_ready.
    - On handshake: if band == N_BANDS-1, go to IDLE and pulse frame_done the same cycle as the final handshake; else band++ and go to DIV.
  - Pixel accumulation continues in all states; input is never back-pressured.
- Divider:
  - Restoring, 1 quotient bit per cycle.
  - start -> done latency exactly SX_W+1 cycles.
  - Quotient truncated to clog2(IMG_W) bits; this is always sufficient because x <= IMG_W-1.
- Latency: EOF to first res_valid = SX_W+3 cycles with a valid band, 2 cycles with a lost band.
- Reset mid-operation: everything returns to reset values immediately; no partial record is emitted.

Decomposition:
- Package mbc_pkg holds:
  - the state enum (IDLE, DIV, OUT)
  - the SX_W/SP_W width functions
  - the result record struct {band, x, count, lost}
- One sub-module: serial_divider #(NUM_W, DEN_W, Q_W), with ports clk, rst, start, numer, denom, busy, done, quotient.
- Band-row decode, accumulators and FSM live in the top level.

Test Plan:
1. Vertical line at x=100, 3 px wide (x=99..101) in all rows, res_ready=1 -> four records in band order 0..3, each x=100, count=96, lost=0; then frame_done.
2. Blank frame -> four records with lost=1, x=0, count=0; first record 2 cycles after EOF.
3. Diagonal line, one px/row: band 0 rows 448..479 at x=row-400 -> band 0 x=63; upper bands give distinct x values matching the floor division model.
4. res_ready held low for 50 cycles on band 1 -> res_* stable throughout; second frame EOF during the stall -> overrun=1, band 2 and 3 records still come from the first frame.
5. sof injected at (x=10, y=300), then a full frame with a line at x=200 -> frame_err pulse; results show x=200 only, with no contamination from the partial frame.
6. rst asserted in DIV for band 2 -> res_valid=0 next cycle; the next full frame gives correct records starting at band 0.

Source files
------------

// File: rtl/mbc_pkg.sv
// Shared types and width helpers for the multi-band centroid tracker.
package mbc_pkg;

  typedef enum logic [1:0] {StIdle, StDiv, StOut} state_e;

  localparam int unsigned MaxBandW = 3;
  localparam int unsigned MaxXW    = 16;
  localparam int unsigned MaxCntW  = 32;

  // Fields are sized for the largest supported configuration; the top trims them.
  typedef struct packed {
    logic [MaxBandW-1:0] band;
    logic [MaxXW-1:0]    x;
    logic [MaxCntW-1:0]  count;
    logic                lost;
  } res_rec_t;

  function automatic int unsigned sx_width(int unsigned img_w, int unsigned band_h);
    return $clog2(band_h * img_w * img_w / 2 + 1);
  endfunction

  function automatic int unsigned sp_width(int unsigned img_w, int unsigned band_h);
    return $clog2(band_h * img_w + 1);
  endfunction

endpackage

// File: rtl/multi_band_centroid_serial_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses NUM_W+1 cycles after start.
module serial_divider #(
  parameter int unsigned NUM_W = 23,
  parameter int unsigned DEN_W = 15,
  parameter int unsigned Q_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned CntW = $clog2(NUM_W + 1);

  // Numerator bits shift out of the top while quotient bits shift in at the bottom.
  logic [NUM_W-1:0] nq_q, nq_d;
  logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DEN_W:0]   trial;

  always_comb begin
    trial  = {rem_q, nq_q[NUM_W-1]};
    nq_d   = nq_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      nq_d   = numer;
      rem_d  = '0;
      den_d  = denom;
      cnt_d  = CntW'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = trial[DEN_W-1:0] - den_q;
        nq_d  = {nq_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        nq_d  = {nq_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nq_q   <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      nq_q   <= nq_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = nq_q[Q_W-1:0];

endmodule

// File: rtl/multi_band_centroid.sv
// Per-band x-centroid tracker: accumulates on-pixels in bottom bands, divides and emits
// one record per band after each frame.
module multi_band_centroid
  import mbc_pkg::*;
#(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned PIX_W   = 4,
  parameter int unsigned N_BANDS = 4,
  parameter int unsigned BAND_H  = 32,
  parameter int unsigned THRESH  = 0,
  parameter int unsigned MIN_PIX = 1,
  localparam int unsigned SxW = sx_width(IMG_W, BAND_H),
  localparam int unsigned SpW = sp_width(IMG_W, BAND_H),
  localparam int unsigned XW  = $clog2(IMG_W),
  localparam int unsigned YW  = $clog2(IMG_H),
  localparam int unsigned BW  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             sof,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BW-1:0]    res_band,
  output logic [XW-1:0]    res_x,
  output logic [SpW-1:0]   res_count,
  output logic             res_lost,
  output logic             frame_done,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [PIX_W-1:0] Thresh   = PIX_W'(THRESH);
  localparam logic [SpW-1:0]   MinPix   = SpW'(MIN_PIX);
  localparam logic [BW-1:0]    LastBand = BW'(N_BANDS - 1);

  logic [XW-1:0]      x_q, x_d, cur_x;
  logic [YW-1:0]      y_q, y_d, cur_y;
  logic               eof, sof_err, pix_on, frame_err_q, overrun_q;
  logic [N_BANDS-1:0] hit;
  logic [SxW-1:0]     sum_q [N_BANDS];
  logic [SxW-1:0]     sum_add [N_BANDS];
  logic [SxW-1:0]     snap_sum_q [N_BANDS];
  logic [SpW-1:0]     cnt_q [N_BANDS];
  logic [SpW-1:0]     cnt_add [N_BANDS];
  logic [SpW-1:0]     snap_cnt_q [N_BANDS];
  state_e             state_q, state_d;
  logic [BW-1:0]      band_q, band_d;
  logic [SxW-1:0]     sel_sum;
  logic [SpW-1:0]     sel_cnt;
  logic               band_lost, div_start, div_busy, div_done;
  logic [XW-1:0]      div_quot;
  res_rec_t           rec;
  logic               unused_rec;

  // sof forces the current pixel to (0,0) regardless of the running counters.
  always_comb begin
    sof_err = pix_valid && sof && ((x_q != '0) || (y_q != '0));
    cur_x   = (pix_valid && sof) ? '0 : x_q;
    cur_y   = (pix_valid && sof) ? '0 : y_q;
    eof     = pix_valid && (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));
    x_d     = x_q;
    y_d     = y_q;
    if (pix_valid) begin
      if (cur_x == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  always_comb begin
    pix_on = pix_data > Thresh;
    for (int k = 0; k < N_BANDS; k++) begin
      hit[k] = pix_valid && pix_on &&
               (int'(cur_y) >= int'(IMG_H) - (k + 1) * int'(BAND_H)) &&
               (int'(cur_y) <= int'(IMG_H) - k * int'(BAND_H) - 1);
      sum_add[k] = (sof_err ? '0 : sum_q[k]) + (hit[k] ? SxW'(cur_x) : '0);
      cnt_add[k] = (sof_err ? '0 : cnt_q[k]) + SpW'(hit[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < N_BANDS; k++) begin
        sum_q[k]      <= '0;
        cnt_q[k]      <= '0;
        snap_sum_q[k] <= '0;
        snap_cnt_q[k] <= '0;
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_err_q <= sof_err;
      if (eof && (state_q != StIdle)) overrun_q <= 1'b1;
      for (int k = 0; k < N_BANDS; k++) begin
        sum_q[k] <= eof ? '0 : sum_add[k];
        cnt_q[k] <= eof ? '0 : cnt_add[k];
        // Pending results keep their snapshot; the new frame is dropped.
        if (eof && (state_q == StIdle)) begin
          snap_sum_q[k] <= sum_add[k];
          snap_cnt_q[k] <= cnt_add[k];
        end
      end
    end
  end

  assign sel_sum   = snap_sum_q[band_q];
  assign sel_cnt   = snap_cnt_q[band_q];
  assign band_lost = sel_cnt < MinPix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      band_q  <= '0;
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
    end
  end

  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    case (state_q)
      StIdle: begin
        if (eof) begin
          state_d = StDiv;
          band_d  = '0;
        end
      end
      StDiv: begin
        if (band_lost || div_done) state_d = StOut;
      end
      StOut: begin
        if (res_ready) begin
          if (band_q == LastBand) begin
            state_d = StIdle;
            band_d  = '0;
          end else begin
            state_d = StDiv;
            band_d  = band_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rec        = '0;
    res_valid  = 1'b0;
    frame_done = 1'b0;
    div_start  = 1'b0;
    case (state_q)
      StDiv: div_start = !band_lost && !div_busy && !div_done;
      StOut: begin
        res_valid  = 1'b1;
        frame_done = res_ready && (band_q == LastBand);
        rec.band   = MaxBandW'(band_q);
        rec.x      = band_lost ? '0 : MaxXW'(div_quot);
        rec.count  = MaxCntW'(sel_cnt);
        rec.lost   = band_lost;
      end
      default: ;
    endcase
  end

  serial_divider #(
    .NUM_W(SxW),
    .DEN_W(SpW),
    .Q_W  (XW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .numer   (sel_sum),
    .denom   (sel_cnt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );

  assign res_band   = rec.band[BW-1:0];
  assign res_x      = rec.x[XW-1:0];
  assign res_count  = rec.count[SpW-1:0];
  assign res_lost   = rec.lost;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign unused_rec = ^rec;

endmodule

// File: tb/tb_multi_band_centroid.sv
// Directed bench for multi_band_centroid on a reduced 32x16 frame with four 3-row bands.
module tb_multi_band_centroid;

  localparam int IMG_W   = 32;
  localparam int IMG_H   = 16;
  localparam int PIX_W   = 4;
  localparam int N_BANDS = 4;
  localparam int BAND_H  = 3;
  localparam int THRESH  = 0;
  localparam int MIN_PIX = 1;
  localparam int SxW     = $clog2(BAND_H * IMG_W * IMG_W / 2 + 1);
  localparam int SpW     = $clog2(BAND_H * IMG_W + 1);
  localparam int XW      = $clog2(IMG_W);
  localparam int BW      = 2;
  localparam int FrameN  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             sof;
  logic             res_valid;
  logic             res_ready;
  logic [BW-1:0]    res_band;
  logic [XW-1:0]    res_x;
  logic [SpW-1:0]   res_count;
  logic             res_lost;
  logic             frame_done;
  logic             overrun;
  logic             frame_err;

  int checks      = 0;
  int errors      = 0;
  int err_pulses  = 0;
  int done_pulses = 0;
  bit stream_done = 1'b0;

  always #5 clk = ~clk;

  multi_band_centroid #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .N_BANDS(N_BANDS),
    .BAND_H (BAND_H),
    .THRESH (THRESH),
    .MIN_PIX(MIN_PIX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .sof       (sof),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_band  (res_band),
    .res_x     (res_x),
    .res_count (res_count),
    .res_lost  (res_lost),
    .frame_done(frame_done),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always @(posedge clk) begin
    if (frame_err === 1'b1) err_pulses <= err_pulses + 1;
    if (frame_done === 1'b1) done_pulses <= done_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit on_pix(input int p, input int x, input int y);
    case (p)
      1:       return (x >= 9) && (x <= 11);
      2:       return (x == 2 * y) || (x == 0 && y == 13) || (x == 3 && y == 10);
      3:       return x == 5;
      4:       return x == 20;
      default: return 1'b0;
    endcase
  endfunction

  // Streams n raster pixels of pattern p, sof on the first; returns one cycle after the last.
  task automatic send_pixels(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      sof       = (i == 0);
      pix_data  = on_pix(p, i % IMG_W, i / IMG_W) ? PIX_W'(1 + (i % IMG_W) % 15) : '0;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_data  = '0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("valid_seen", res_valid, 1);
  endtask

  task automatic expect_rec(input int band, input int x, input int cnt, input int lost);
    int n;
    wait_valid(100, n);
    check("rec_band", res_band, band);
    check("rec_x", res_x, x);
    check("rec_count", res_count, cnt);
    check("rec_lost", res_lost, lost);
    check("rec_frame_done", frame_done, (band == N_BANDS - 1) ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    sof       = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", res_valid, 0);
    check("rst_band", res_band, 0);
    check("rst_x", res_x, 0);
    check("rst_count", res_count, 0);
    check("rst_lost", res_lost, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vertical 3-px line at x=9..11: 9 px per band, centroid 10.
    send_pixels(1, FrameN);
    wait_valid(100, n);
    check("lat_valid_band", n + 1, SxW + 3);
    for (int k = 0; k < N_BANDS; k++) expect_rec(k, 10, 9, 0);
    check("done_pulses_1", done_pulses, 1);
    check("err_pulses_1", err_pulses, 0);

    // Blank frame: every band lost.
    send_pixels(0, FrameN);
    wait_valid(100, n);
    check("lat_lost_band", n + 1, 2);
    for (int k = 0; k < N_BANDS; k++) expect_rec(k, 0, 0, 1);

    // Diagonal with extra pixels: floors 84/4, 69/4, 48/3, 30/3.
    send_pixels(2, FrameN);
    expect_rec(0, 21, 4, 0);
    expect_rec(1, 17, 4, 0);
    expect_rec(2, 16, 3, 0);
    expect_rec(3, 10, 3, 0);
    check("overrun_before_stall", overrun, 0);

    // Stall on band 1 across a whole second frame.
    send_pixels(1, FrameN);
    expect_rec(0, 10, 9, 0);
    res_ready   = 1'b0;
    stream_done = 1'b0;
    fork
      begin
        send_pixels(0, FrameN);
        stream_done = 1'b1;
      end
      begin
        int m;
        wait_valid(100, m);
        while (!stream_done) begin
          check("stall_rec", {res_valid, res_band, res_x, res_count, res_lost},
                {1'b1, 2'd1, 5'd10, 7'd9, 1'b0});
          @(posedge clk);
          #1;
        end
      end
    join
    check("overrun_set", overrun, 1);
    res_ready = 1'b1;
    expect_rec(1, 10, 9, 0);
    expect_rec(2, 10, 9, 0);
    expect_rec(3, 10, 9, 0);
    repeat (30) @(posedge clk);
    #1;
    check("no_record_after_overrun", res_valid, 0);

    // Partial frame stopped at (10,8), then a mid-frame sof starts a clean frame.
    send_pixels(3, 8 * IMG_W + 10);
    check("err_pulses_before_sof", err_pulses, 0);
    send_pixels(4, FrameN);
    check("err_pulses_after_sof", err_pulses, 1);
    for (int k = 0; k < N_BANDS; k++) expect_rec(k, 20, 3, 0);
    check("overrun_sticky", overrun, 1);

    // Reset while band 2 is dividing.
    send_pixels(1, FrameN);
    expect_rec(0, 10, 9, 0);
    expect_rec(1, 10, 9, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", res_valid, 0);
    check("rst_mid_overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_record_after_rst", res_valid, 0);
    send_pixels(2, FrameN);
    expect_rec(0, 21, 4, 0);
    expect_rec(1, 17, 4, 0);
    expect_rec(2, 16, 3, 0);
    expect_rec(3, 10, 3, 0);
    check("done_pulses_total", done_pulses, 6);
    check("err_pulses_total", err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
